// File: rtl/if_stage_fq_pkg.sv
// if_stage_fq_pkg: shared fetch-stage constants, redirect causes and queue entry type
package if_stage_fq_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [29:0] RESET_PC = 30'h0;
  typedef enum logic [2:0] {RD_NONE, RD_START, RD_TRAP, RD_XRET, RD_JMP} rd_cause_t;
  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] inst;
  } fq_entry_t;
  // xret/jmp are ignored in the cycle after a trap so a late EX redirect cannot override mtvec
  function automatic rd_cause_t rd_cause(input logic start, input logic trap, input logic xret,
                                         input logic jmp, input logic post_trap);
    return start ? RD_START : trap ? RD_TRAP : (xret & ~post_trap) ? RD_XRET :
           (jmp & ~post_trap) ? RD_JMP : RD_NONE;
  endfunction
endpackage

// File: rtl/if_stage_fq_fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, inst} entries with flush and occupancy count
// Ports: clk, rst_n; push/din; pop; flush clears all entries; head is the combinational oldest entry; count
module fetch_queue
  import if_stage_fq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fq_entry_t                din,
  input  logic                     pop,
  input  logic                     flush,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fq_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & ~flush;
  assign do_pop = pop & ~flush & (count != '0);
  assign head = mem[rp];
  always_ff @(posedge clk) if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // the issue credit check upstream must make this unreachable
  always_ff @(posedge clk) if (rst_n && do_push) assert (count != (AW+1)'(DEPTH));
endmodule

// File: rtl/inst_1r1w.sv
// inst_1r1w: instruction RAM, one registered read port and one write port
// Ports: clk; radr/rdata read (1-cycle latency, read-old on collision); wadr/wdata/wen write
module inst_1r1w #(
  parameter int IWIDTH = 12
) (
  input  logic              clk,
  input  logic [IWIDTH-1:0] radr,
  output logic [31:0]       rdata,
  input  logic [IWIDTH-1:0] wadr,
  input  logic [31:0]       wdata,
  input  logic              wen
);
  logic [31:0] mem [2**IWIDTH];
  always_ff @(posedge clk) begin
    if (wen) mem[wadr] <= wdata;
    rdata <= mem[radr];
  end
endmodule

// File: rtl/if_stage_fq.sv
// if_stage_fq: RV32I fetch stage with redirect priority, iRAM access and a credit-controlled fetch queue
// Ports: redirects (cpu_start/trap/xret/jmp), rst_pipe flush; id_valid/id_ready handoff with inst_id/pc_id;
// monitor iRAM access (i_read_sel, i_ram_*); pc_data, fq_count, post_jump_cmd_cond status
module if_stage_fq
  import if_stage_fq_pkg::*;
#(
  parameter int IWIDTH   = 12,
  parameter int FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_start,
  input  logic [29:0]                 start_adr,
  input  logic                        rst_pipe,
  input  logic                        trap_ex,
  input  logic [29:0]                 trap_adr_ex,
  input  logic                        xret_ex,
  input  logic [29:0]                 xret_adr_ex,
  input  logic                        jmp_ex,
  input  logic [29:0]                 jmp_adr_ex,
  output logic                        id_valid,
  input  logic                        id_ready,
  output logic [31:0]                 inst_id,
  output logic [29:0]                 pc_id,
  output logic                        post_jump_cmd_cond,
  input  logic                        i_read_sel,
  input  logic [IWIDTH-1:0]           i_ram_radr,
  output logic [31:0]                 i_ram_rdata,
  input  logic [IWIDTH-1:0]           i_ram_wadr,
  input  logic [31:0]                 i_ram_wdata,
  input  logic                        i_ram_wen,
  output logic [31:0]                 pc_data,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  rd_cause_t cause;
  fq_entry_t head;
  logic [29:0] pc_if, tag, target, last_pc;
  logic [31:0] ram_q;
  logic post_trap, inflight, flush, fetch_en;
  assign cause = rd_cause(cpu_start, trap_ex, xret_ex, jmp_ex, post_trap);
  assign target = cause == RD_START ? start_adr : cause == RD_TRAP ? trap_adr_ex :
                  cause == RD_XRET ? xret_adr_ex : jmp_adr_ex;
  assign flush = (cause != RD_NONE) | rst_pipe;
  // reads already in flight hold a queue slot, so a returning word always has room
  assign fetch_en = ~i_read_sel & ~flush & (fq_count + CW'(inflight) < CW'(FQ_DEPTH));
  assign id_valid = fq_count != '0;
  assign inst_id = id_valid ? head.inst : NOP_INST;
  assign pc_id = id_valid ? head.pc : last_pc;
  assign pc_data = {pc_if, 2'b00};
  assign i_ram_rdata = ram_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_if <= RESET_PC;
      tag <= '0;
      last_pc <= '0;
      inflight <= 1'b0;
      post_trap <= 1'b0;
      post_jump_cmd_cond <= 1'b0;
    end else begin
      post_trap <= trap_ex;
      post_jump_cmd_cond <= jmp_ex | xret_ex;
      inflight <= fetch_en;
      if (fetch_en) tag <= pc_if;
      pc_if <= cause != RD_NONE ? target : fetch_en ? pc_if + 1'b1 : pc_if;
      if (id_valid & id_ready & ~flush) last_pc <= head.pc;
    end
  inst_1r1w #(.IWIDTH(IWIDTH)) u_iram (
    .clk   (clk),
    .radr  (i_read_sel ? i_ram_radr : pc_if[IWIDTH-1:0]),
    .rdata (ram_q),
    .wadr  (i_ram_wadr),
    .wdata (i_ram_wdata),
    .wen   (i_ram_wen)
  );
  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight & ~flush),
    .din   ({tag, ram_q}),
    .pop   (id_valid & id_ready),
    .flush (flush),
    .head  (head),
    .count (fq_count)
  );
endmodule

// File: tb/tb_if_stage_fq.sv
// tb_if_stage_fq: randomized scoreboard bench for the fetch stage against a sequential-stream reference model
module tb_if_stage_fq;
  localparam int IW = 8;
  localparam int FQD = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_start = 1'b0, rst_pipe = 1'b0, trap_ex = 1'b0, xret_ex = 1'b0, jmp_ex = 1'b0;
  logic [29:0] start_adr = '0, trap_adr_ex = '0, xret_adr_ex = '0, jmp_adr_ex = '0;
  logic id_ready = 1'b0, i_read_sel = 1'b0, i_ram_wen = 1'b0;
  logic [IW-1:0] i_ram_radr = '0, i_ram_wadr = '0;
  logic [31:0] i_ram_wdata = '0;
  logic id_valid, post_jump_cmd_cond;
  logic [31:0] inst_id, i_ram_rdata, pc_data;
  logic [29:0] pc_id;
  logic [2:0] fq_count;
  typedef struct {
    logic [29:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] mem_m [2**IW];
  int n_cmp = 0, n_err = 0, n_pop = 0;
  bit mon_en = 0, flush_cyc = 0, prev_trap = 0, rd_pend = 0, pj_exp = 0;
  logic [29:0] next_exp = '0, last_pop = '0;

  if_stage_fq #(.IWIDTH(IW), .FQ_DEPTH(FQD)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_start(cpu_start), .start_adr(start_adr), .rst_pipe(rst_pipe),
    .trap_ex(trap_ex), .trap_adr_ex(trap_adr_ex), .xret_ex(xret_ex), .xret_adr_ex(xret_adr_ex),
    .jmp_ex(jmp_ex), .jmp_adr_ex(jmp_adr_ex), .id_valid(id_valid), .id_ready(id_ready),
    .inst_id(inst_id), .pc_id(pc_id), .post_jump_cmd_cond(post_jump_cmd_cond),
    .i_read_sel(i_read_sel), .i_ram_radr(i_ram_radr), .i_ram_rdata(i_ram_rdata),
    .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen),
    .pc_data(pc_data), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: after a redirect to T the ID stage must see T, T+1, T+2 ... in order; entries
  // are queued ahead of time and the whole expectation is discarded on the next redirect.
  task automatic step();
    bit xj;
    bit redir;
    logic [29:0] tgt;
    xj = ~prev_trap & (xret_ex | jmp_ex);
    redir = cpu_start | trap_ex | xj;
    flush_cyc = redir | rst_pipe;
    if (redir) begin
      if (cpu_start) tgt = start_adr;
      else if (trap_ex) tgt = trap_adr_ex;
      else if (xret_ex) tgt = xret_adr_ex;
      else tgt = jmp_adr_ex;
      exp_q.delete();
      next_exp = tgt;
    end else if (rst_pipe) begin
      // only used with a stalled full queue: the PC already points past the dropped entries
      next_exp = exp_q[0].pc + 30'(FQD);
      exp_q.delete();
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: next_exp, inst: mem_m[next_exp[IW-1:0]]});
      next_exp = next_exp + 30'd1;
    end
    prev_trap = trap_ex;
    if (mon_en && i_read_sel) rd_q.push_back(mem_m[i_ram_radr]);
    if (i_ram_wen) mem_m[i_ram_wadr] = i_ram_wdata;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rd_pend) begin
        if (rd_q.size() == 0) chk("rd_q_underflow", 1, 0);
        else chk("ram_rdata", i_ram_rdata, rd_q.pop_front());
      end
      chk("post_jump", post_jump_cmd_cond, pj_exp);
      chk("fq_bound", 64'(fq_count <= 3'(FQD)), 1);
      if (!id_valid) chk("nop_when_empty", inst_id, NOP);
      if (id_valid && id_ready && !flush_cyc) begin
        if (exp_q.size() == 0) chk("exp_q_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pc_id", pc_id, e.pc);
          chk("inst_id", inst_id, e.inst);
          last_pop = pc_id;
          n_pop++;
        end
      end
    end
    rd_pend = mon_en & i_read_sel;
    pj_exp = jmp_ex | xret_ex;
  end

  initial begin
    logic [31:0] orig;
    logic [31:0] p;
    logic [29:0] h;
    int r;
    @(posedge clk);
    #1;
    i_ram_wen = 1'b1;
    for (int i = 0; i < 2**IW; i++) begin
      i_ram_wadr = IW'(i);
      i_ram_wdata = $urandom;
      step();
    end
    i_ram_wen = 1'b0;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_inst_id", inst_id, NOP);
    chk("rst_pc_id", pc_id, 0);
    chk("rst_fq_count", fq_count, 0);
    chk("rst_pc_data", pc_data, 0);
    chk("rst_post_jump", post_jump_cmd_cond, 0);
    exp_q.delete();
    next_exp = '0;
    rst_n = 1'b1;
    mon_en = 1;
    step();
    // start at 0x100 and stream back-to-back
    cpu_start = 1'b1;
    start_adr = 30'h40;
    id_ready = 1'b1;
    step();
    cpu_start = 1'b0;
    step();
    chk("start_lat1_valid", id_valid, 0);
    step();
    chk("start_lat2_valid", id_valid, 1);
    chk("start_first_pc", pc_id, 30'h40);
    chk("start_first_inst", inst_id, mem_m[8'h40]);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("b2b_valid", id_valid, 1);
      chk("b2b_pc", pc_id, 30'h40 + 30'(k));
    end
    // backpressure saturates the queue and stops the PC
    id_ready = 1'b0;
    repeat (10) step();
    chk("stall_count", fq_count, FQD);
    p = pc_data;
    step();
    chk("stall_pc_hold", pc_data, p);
    id_ready = 1'b1;
    repeat (8) step();
    // jump with a full queue
    id_ready = 1'b0;
    repeat (6) step();
    chk("full_before_jmp", fq_count, FQD);
    jmp_ex = 1'b1;
    jmp_adr_ex = 30'h200;
    step();
    jmp_ex = 1'b0;
    chk("jmp_flush_count", fq_count, 0);
    chk("jmp_flush_valid", id_valid, 0);
    chk("jmp_post_jump", post_jump_cmd_cond, 1);
    step();
    chk("jmp_lat1_valid", id_valid, 0);
    chk("jmp_post_jump_clr", post_jump_cmd_cond, 0);
    step();
    chk("jmp_lat2_valid", id_valid, 1);
    chk("jmp_pc", pc_id, 30'h200);
    id_ready = 1'b1;
    repeat (4) step();
    // trap beats jmp, and a jmp in the following cycle is suppressed
    id_ready = 1'b0;
    repeat (3) step();
    trap_ex = 1'b1;
    trap_adr_ex = 30'h0C00;
    jmp_ex = 1'b1;
    jmp_adr_ex = 30'h123;
    step();
    trap_ex = 1'b0;
    jmp_adr_ex = 30'h456;
    step();
    jmp_ex = 1'b0;
    chk("trap_lat1_valid", id_valid, 0);
    step();
    chk("trap_lat2_valid", id_valid, 1);
    chk("trap_pc", pc_id, 30'h0C00);
    id_ready = 1'b1;
    repeat (4) step();
    // monitor port: write then read back, no fetch while selected
    orig = mem_m[5];
    i_read_sel = 1'b1;
    i_ram_radr = 8'd5;
    i_ram_wen = 1'b1;
    i_ram_wadr = 8'd5;
    i_ram_wdata = 32'hDEAD_BEEF;
    step();
    chk("mon_read_old", i_ram_rdata, orig);
    p = pc_data;
    i_ram_wen = 1'b0;
    step();
    chk("mon_read_new", i_ram_rdata, 32'hDEAD_BEEF);
    step();
    chk("mon_no_fetch_pc", pc_data, p);
    chk("mon_queue_drained", fq_count, 0);
    i_ram_wen = 1'b1;
    i_ram_wdata = orig;
    step();
    i_ram_wen = 1'b0;
    i_read_sel = 1'b0;
    repeat (6) step();
    // rst_pipe drops queued entries but keeps the PC
    id_ready = 1'b0;
    repeat (8) step();
    h = pc_data[31:2];
    rst_pipe = 1'b1;
    step();
    rst_pipe = 1'b0;
    chk("rst_pipe_count", fq_count, 0);
    chk("rst_pipe_valid", id_valid, 0);
    chk("rst_pipe_pc_hold", pc_data, {h, 2'b00});
    chk("rst_pipe_pc_id_last", pc_id, last_pop);
    id_ready = 1'b1;
    repeat (6) step();
    // 30-bit PC wrap
    cpu_start = 1'b1;
    start_adr = 30'h3FFF_FFFF;
    step();
    cpu_start = 1'b0;
    chk("wrap_pc_load", pc_data, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc_data", pc_data, 0);
    step();
    chk("wrap_pc_id0", pc_id, 30'h3FFF_FFFF);
    step();
    chk("wrap_pc_id1", pc_id, 0);
    repeat (4) step();
    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      id_ready = ($urandom % 4) != 0;
      i_read_sel = ($urandom % 8) == 0;
      i_ram_radr = IW'($urandom);
      r = int'($urandom % 40);
      cpu_start = r == 0;
      trap_ex = r == 1 || r == 2;
      xret_ex = r == 3 || r == 2;
      jmp_ex = r == 4 || r == 5 || r == 2 || (prev_trap && ($urandom % 2) == 0);
      start_adr = 30'($urandom);
      trap_adr_ex = 30'($urandom);
      xret_adr_ex = 30'($urandom);
      jmp_adr_ex = 30'($urandom);
      step();
    end
    {cpu_start, trap_ex, xret_ex, jmp_ex, i_read_sel} = '0;
    id_ready = 1'b1;
    repeat (6) step();
    chk("pop_progress", 64'(n_pop > 300), 1);
    // asynchronous reset in mid-stream
    mon_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_id_valid", id_valid, 0);
    chk("areset_inst_id", inst_id, NOP);
    chk("areset_pc_id", pc_id, 0);
    chk("areset_fq_count", fq_count, 0);
    chk("areset_pc_data", pc_data, 0);
    chk("areset_post_jump", post_jump_cmd_cond, 0);
    exp_q.delete();
    rd_q.delete();
    next_exp = '0;
    prev_trap = 0;
    repeat (2) step();
    rst_n = 1'b1;
    mon_en = 1;
    repeat (12) step();
    chk("after_reset_stream", 64'(last_pop != 30'h0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
